// File: rtl/tmds_pkg.sv
// Shared constants and stage-1 payload for the TMDS 8b/10b channel encoder.
// TMDS_TERC4_EN adds the TERC4 auxiliary fields to the stage-1 payload.
package tmds_pkg;

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned DATA_W = 8;

    // Blanking control tokens, indexed by {c1, c0}
    localparam logic [SYM_W-1:0] CTL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTL_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] TERC4_TBL [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef struct packed {
        logic [DATA_W:0] q_m;
        logic [3:0]      n1q;
        logic            de;
        logic [1:0]      c1c0;
`ifdef TMDS_TERC4_EN
        logic            ade;
        logic [3:0]      aux;
`endif
    } stage1_t;

endpackage

// File: rtl/tmds_popcnt8.sv
// Ones counter for an 8-bit word.
module tmds_popcnt8 (
    input  logic [7:0] data,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(data[i]);
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// Single-channel TMDS 8b/10b encoder, two-stage pipeline, one symbol per clock.
// Define TMDS_TERC4_EN to add the ade/aux ports and TERC4 data-island symbols.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             c0,
    input  logic             c1,
    input  logic             de,
`ifdef TMDS_TERC4_EN
    input  logic             ade,
    input  logic [3:0]       aux,
`endif
    output logic [SYM_W-1:0] dout
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [3:0]              n1d;
    logic [3:0]              n1m;
    logic                    dec1;
    logic                    acc;
    logic [DATA_W:0]         q_m;
    stage1_t                 s1_d;
    stage1_t                 s1_q;

    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] n1s;
    logic signed [CNT_W-1:0] n0s;
    logic [3:0]              n0q;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic                    q8;
    logic [DATA_W-1:0]       qd;
    logic [SYM_W-1:0]        dout_d;

    tmds_popcnt8 u_pop_din (
        .data  (din),
        .count (n1d)
    );

    tmds_popcnt8 u_pop_qm (
        .data  (q_m[7:0]),
        .count (n1m)
    );

    // Transition-minimizing XOR/XNOR chain
    always_comb begin
        dec1   = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
        q_m    = '0;
        acc    = din[0];
        q_m[0] = acc;
        for (int i = 1; i < 8; i++) begin
            acc    = dec1 ? ~(acc ^ din[i]) : (acc ^ din[i]);
            q_m[i] = acc;
        end
        q_m[8] = ~dec1;
    end

    always_comb begin
        s1_d      = '0;
        s1_d.q_m  = q_m;
        s1_d.n1q  = n1m;
        s1_d.de   = de;
        s1_d.c1c0 = {c1, c0};
`ifdef TMDS_TERC4_EN
        s1_d.ade  = ade;
        s1_d.aux  = aux;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // DC-balancing stage: choose inversion from running disparity
    always_comb begin
        dout_d  = CTL_00;
        cnt_d   = cnt;
        q8      = s1_q.q_m[8];
        qd      = s1_q.q_m[7:0];
        n0q     = 4'd8 - s1_q.n1q;
        n1s     = CNT_W'(s1_q.n1q);
        n0s     = CNT_W'(n0q);
        cnt_neg = cnt[CNT_W-1];
        cnt_pos = !cnt[CNT_W-1] && (cnt != '0);

        if (!s1_q.de) begin
            cnt_d = '0;
            unique case (s1_q.c1c0)
                2'b00:   dout_d = CTL_00;
                2'b01:   dout_d = CTL_01;
                2'b10:   dout_d = CTL_10;
                default: dout_d = CTL_11;
            endcase
`ifdef TMDS_TERC4_EN
            if (s1_q.ade) begin
                dout_d = TERC4_TBL[s1_q.aux];
            end
`endif
        end else if ((cnt == '0) || (s1_q.n1q == n0q)) begin
            dout_d = {~q8, q8, q8 ? qd : ~qd};
            cnt_d  = q8 ? (cnt + n1s - n0s) : (cnt + n0s - n1s);
        end else if ((cnt_pos && (s1_q.n1q > n0q)) || (cnt_neg && (n0q > s1_q.n1q))) begin
            dout_d = {1'b1, q8, ~qd};
            cnt_d  = cnt + (q8 ? TWO : '0) + n0s - n1s;
        end else begin
            dout_d = {1'b0, q8, qd};
            cnt_d  = cnt + n1s - n0s - (q8 ? '0 : TWO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= CTL_00;
            cnt  <= '0;
        end else begin
            dout <= dout_d;
            cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder; TERC4 checks compile in with TMDS_TERC4_EN.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       c0;
    logic       c1;
    logic       de;
    logic [9:0] dout;
`ifdef TMDS_TERC4_EN
    logic       ade;
    logic [3:0] aux;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam int NV = 22;

    typedef struct {
        logic       de;
        logic [1:0] c;
        logic [7:0] din;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    tmds_encoder #(.CNT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .c0   (c0),
        .c1   (c1),
        .de   (de),
`ifdef TMDS_TERC4_EN
        .ade  (ade),
        .aux  (aux),
`endif
        .dout (dout)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dout=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic [1:0] c, input logic [7:0] x);
        de       = d;
        {c1, c0} = c;
        din      = x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Chained vectors; expected symbols hand-derived with running disparity noted
        vecs[0]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100};
        vecs[1]  = '{1'b0, 2'b01, 8'h00, 10'b0010101011};
        vecs[2]  = '{1'b0, 2'b10, 8'h00, 10'b0101010100};
        vecs[3]  = '{1'b0, 2'b11, 8'h00, 10'b1010101011};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 10'b0100000000}; // cnt -8
        vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'b1111111111}; // cnt 2
        vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'b0100000000}; // cnt -6
        vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100}; // cnt 0
        vecs[8]  = '{1'b1, 2'b00, 8'hFF, 10'b1000000000}; // cnt -8
        vecs[9]  = '{1'b0, 2'b00, 8'h00, 10'b1101010100}; // cnt 0
        vecs[10] = '{1'b1, 2'b00, 8'h00, 10'b0100000000}; // cnt -8
        vecs[11] = '{1'b0, 2'b00, 8'h00, 10'b1101010100}; // cnt 0
        vecs[12] = '{1'b1, 2'b00, 8'h00, 10'b0100000000}; // cnt -8
        vecs[13] = '{1'b1, 2'b00, 8'h01, 10'b0111111111}; // cnt 0
        vecs[14] = '{1'b1, 2'b11, 8'h55, 10'b0100110011}; // cnt 0
        vecs[15] = '{1'b1, 2'b00, 8'h10, 10'b0111110000}; // cnt 0
        vecs[16] = '{1'b1, 2'b00, 8'hAA, 10'b1000110011}; // cnt 0
        vecs[17] = '{1'b1, 2'b00, 8'h03, 10'b0100000001}; // cnt -6
        vecs[18] = '{1'b1, 2'b00, 8'hF0, 10'b0011111010}; // cnt -4
        vecs[19] = '{1'b1, 2'b00, 8'hFF, 10'b0011111111}; // cnt 2
        vecs[20] = '{1'b1, 2'b00, 8'hFF, 10'b1000000000}; // cnt -6
        vecs[21] = '{1'b0, 2'b10, 8'h00, 10'b0101010100}; // cnt 0

        rst = 1'b1;
        drive(1'b0, 2'b00, 8'h00);
`ifdef TMDS_TERC4_EN
        ade = 1'b0;
        aux = 4'd0;
`endif
        #1;
        check("reset_value", dout, 10'b1101010100);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].de, vecs[i].c, vecs[i].din);
            step();
            if (i > 0) check($sformatf("vec%0d", i - 1), dout, vecs[i - 1].exp);
        end
        step();
        check($sformatf("vec%0d", NV - 1), dout, vecs[NV - 1].exp);

        // Asynchronous reset mid-cycle while streaming data
        drive(1'b1, 2'b00, 8'h00);
        step();
        step();
        check("pre_reset_data", dout, 10'b0100000000);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", dout, 10'b1101010100);
        step();
        check("reset_hold", dout, 10'b1101010100);
        drive(1'b0, 2'b00, 8'h00);
        rst = 1'b0;
        step();
        check("post_reset_0", dout, 10'b1101010100);
        step();
        check("post_reset_1", dout, 10'b1101010100);

        // Reset with data pending: pipeline must flush before the next symbol
        drive(1'b1, 2'b00, 8'h00);
        step();
        step();
        check("flush_pre", dout, 10'b0100000000);
        #3;
        rst = 1'b1;
        #1;
        check("flush_async", dout, 10'b1101010100);
        step();
        rst = 1'b0;
        step();
        check("flush_first", dout, 10'b1101010100);
        step();
        check("flush_data", dout, 10'b0100000000);

`ifdef TMDS_TERC4_EN
        drive(1'b0, 2'b00, 8'h00);
        ade = 1'b1;
        aux = 4'd5;
        step();
        step();
        check("terc4_aux5", dout, 10'b0100011110);
        aux = 4'd12;
        step();
        check("terc4_aux12", dout, 10'b1010001110);
        drive(1'b1, 2'b00, 8'hFF);
        step();
        step();
        check("terc4_de_wins", dout, 10'b1000000000);
        ade = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
